// File: rtl/wb_pkg.sv
// Shared encodings for the writeback unit: source/destination/load-size selects,
// FSM state encoding and a few fixed constants.
package wb_pkg;

  // Writeback data source
  typedef enum logic [1:0] {
    WbAlu  = 2'd0,
    WbMem  = 2'd1,
    WbLink = 2'd2,
    WbRsvd = 2'd3
  } wb_sel_e;

  // Destination register select
  typedef enum logic [1:0] {
    DstRt   = 2'd0,
    DstRd   = 2'd1,
    DstR31  = 2'd2,
    DstRsvd = 2'd3
  } dst_sel_e;

  // Load access size
  typedef enum logic [1:0] {
    LdWord = 2'd0,
    LdHalf = 2'd1,
    LdByte = 2'd2,
    LdRsvd = 2'd3
  } ld_size_e;

  // FSM: StIdle holds no request, StWb holds exactly one captured request
  typedef enum logic {
    StIdle = 1'b0,
    StWb   = 1'b1
  } wb_state_e;

  localparam logic [4:0]  LinkReg    = 5'd31;
  localparam logic [31:0] LinkOffset = 32'd8;

  // Destination address from the instruction fields; the reserved select yields r0
  function automatic logic [4:0] resolve_dst(logic [1:0] dst_sel, logic [4:0] rt, logic [4:0] rd);
    logic [4:0] addr;
    case (dst_sel_e'(dst_sel))
      DstRt:   addr = rt;
      DstRd:   addr = rd;
      DstR31:  addr = LinkReg;
      default: addr = 5'd0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Load formatter: extracts the addressed lane of a loaded word, extends it, and
// flags misaligned or reserved-size accesses. Purely combinational.
module load_formatter
  import wb_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  byte_off,
  output logic [31:0] data,
  output logic        err
);

  logic [15:0] half_lane;
  logic [7:0]  byte_lane;

  // Lane selection: half uses offset bit 1, byte uses the full offset
  always_comb begin
    half_lane = byte_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (byte_off)
      2'd0:    byte_lane = mem_rdata[7:0];
      2'd1:    byte_lane = mem_rdata[15:8];
      2'd2:    byte_lane = mem_rdata[23:16];
      default: byte_lane = mem_rdata[31:24];
    endcase
  end

  // Size decode, extension and alignment checking
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (ld_size_e'(ld_size))
      LdWord: begin
        data = mem_rdata;
        err  = (byte_off != 2'd0);
      end
      LdHalf: begin
        data = {{16{ld_signed & half_lane[15]}}, half_lane};
        err  = byte_off[0];
      end
      LdByte: begin
        data = {{24{ld_signed & byte_lane[7]}}, byte_lane};
        err  = 1'b0;
      end
      default: begin
        data = '0;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: captures one writeback request per cycle, resolves its
// destination and data at capture time, and presents the register-file write
// in the following cycle. hold freezes both capture and write.
module writeback_unit
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        hold,
  input  logic        reg_write,
  input  logic [1:0]  wb_sel,
  input  logic [1:0]  dst_sel,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] pc,
  input  logic [1:0]  ld_size,
  input  logic        ld_signed,
  input  logic [1:0]  byte_off,
  output logic [4:0]  reg_W_addr,
  output logic [31:0] wdata,
  output logic        reg_we,
  output logic        pend_valid,
  output logic [4:0]  pend_addr,
  output logic        align_err
);

  wb_state_e   state_q;
  logic [4:0]  addr_q;
  logic [31:0] wdata_q;
  logic        reg_write_q;
  logic        write_ok_q;
  logic        align_err_q;

  logic [31:0] load_data;
  logic        load_err;
  logic [4:0]  addr_d;
  logic [31:0] wdata_d;
  logic        err_d;
  logic        write_ok_d;
  logic        capture;

  load_formatter u_load_formatter (
    .mem_rdata (mem_rdata),
    .ld_size   (ld_size),
    .ld_signed (ld_signed),
    .byte_off  (byte_off),
    .data      (load_data),
    .err       (load_err)
  );

  // Resolve the incoming request so only final values need to be stored
  always_comb begin
    addr_d  = resolve_dst(dst_sel, rt, rd);
    wdata_d = '0;
    err_d   = (dst_sel_e'(dst_sel) == DstRsvd);
    case (wb_sel_e'(wb_sel))
      WbAlu:   wdata_d = alu_result;
      WbMem: begin
        wdata_d = load_data;
        err_d   = err_d | load_err;
      end
      WbLink:  wdata_d = pc + LinkOffset;
      default: begin
        wdata_d = '0;
        err_d   = 1'b1;
      end
    endcase
    // Writes to r0 are dropped but the request still counts as pending
    write_ok_d = reg_write && (addr_d != 5'd0) && !err_d;
  end

  assign in_ready = !hold;
  assign capture  = in_valid && in_ready;

  // FSM plus captured request; a capture while in StWb overlaps the previous write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      wdata_q     <= '0;
      reg_write_q <= 1'b0;
      write_ok_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      if (capture) begin
        state_q     <= StWb;
        addr_q      <= addr_d;
        wdata_q     <= wdata_d;
        reg_write_q <= reg_write;
        write_ok_q  <= write_ok_d;
        if (err_d) begin
          align_err_q <= 1'b1;
        end
      end else if (state_q == StWb && !hold) begin
        state_q <= StIdle;
      end
    end
  end

  // Write strobe and hazard outputs; hold suppresses the write but keeps data stable
  always_comb begin
    reg_we     = (state_q == StWb) && !hold && write_ok_q;
    pend_valid = (state_q == StWb) && reg_write_q;
    pend_addr  = pend_valid ? addr_q : 5'd0;
    reg_W_addr = addr_q;
    wdata      = wdata_q;
    align_err  = align_err_q;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios followed by
// randomized traffic, checked against a request-level reference model.
module tb_writeback_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        hold;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic [1:0]  dst_sel;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic [31:0] pc;
  logic [1:0]  ld_size;
  logic        ld_signed;
  logic [1:0]  byte_off;
  logic [4:0]  reg_W_addr;
  logic [31:0] wdata;
  logic        reg_we;
  logic        pend_valid;
  logic [4:0]  pend_addr;
  logic        align_err;

  writeback_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .hold       (hold),
    .reg_write  (reg_write),
    .wb_sel     (wb_sel),
    .dst_sel    (dst_sel),
    .rt         (rt),
    .rd         (rd),
    .alu_result (alu_result),
    .mem_rdata  (mem_rdata),
    .pc         (pc),
    .ld_size    (ld_size),
    .ld_signed  (ld_signed),
    .byte_off   (byte_off),
    .reg_W_addr (reg_W_addr),
    .wdata      (wdata),
    .reg_we     (reg_we),
    .pend_valid (pend_valid),
    .pend_addr  (pend_addr),
    .align_err  (align_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  wb;
    logic [1:0]  dst;
    logic [1:0]  sz;
    logic        sgn;
    logic [1:0]  off;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] pc;
  } req_t;

  int   n_tests;
  int   n_fail;
  int   obs_writes;
  req_t m_req;
  bit   m_valid;
  bit   m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: what a request means, computed straight from the rules
  function automatic logic [4:0] ref_addr(req_t r);
    if (r.dst == 2'd0) return r.rt;
    if (r.dst == 2'd1) return r.rd;
    if (r.dst == 2'd2) return 5'd31;
    return 5'd0;
  endfunction

  function automatic bit ref_err(req_t r);
    bit bad_load;
    bad_load = (r.sz == 2'd3) || (r.sz == 2'd0 && r.off != 2'd0) || (r.sz == 2'd1 && r.off[0]);
    return (r.wb == 2'd3) || (r.dst == 2'd3) || (r.wb == 2'd1 && bad_load);
  endfunction

  function automatic logic [31:0] ref_data(req_t r);
    int unsigned width;
    int unsigned shift;
    logic [31:0] mask;
    logic [31:0] v;
    if (r.wb == 2'd0) return r.alu;
    if (r.wb == 2'd2) return r.pc + 32'd8;
    if (r.sz == 2'd0) return r.mem;
    width = (r.sz == 2'd1) ? 16 : 8;
    shift = (r.sz == 2'd1) ? 16 * int'(r.off[1]) : 8 * int'(r.off);
    mask  = (32'd1 << width) - 32'd1;
    v     = (r.mem >> shift) & mask;
    if (r.sgn && v[width-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic req_t cur_req();
    req_t r;
    r.rw  = reg_write;
    r.wb  = wb_sel;
    r.dst = dst_sel;
    r.sz  = ld_size;
    r.sgn = ld_signed;
    r.off = byte_off;
    r.rt  = rt;
    r.rd  = rd;
    r.alu = alu_result;
    r.mem = mem_rdata;
    r.pc  = pc;
    return r;
  endfunction

  task automatic set_req(input logic rw, input logic [1:0] wb, input logic [1:0] dst,
                         input logic [1:0] sz, input logic sgn, input logic [1:0] off,
                         input logic [4:0] rt_v, input logic [4:0] rd_v,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc_v);
    in_valid   = 1'b1;
    reg_write  = rw;
    wb_sel     = wb;
    dst_sel    = dst;
    ld_size    = sz;
    ld_signed  = sgn;
    byte_off   = off;
    rt         = rt_v;
    rd         = rd_v;
    alu_result = alu;
    mem_rdata  = mem;
    pc         = pc_v;
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "/reg_we"}, reg_we, 1'b0);
    check_eq({tag, "/pend_valid"}, pend_valid, 1'b0);
    check_eq({tag, "/pend_addr"}, pend_addr, 5'd0);
    check_eq({tag, "/reg_W_addr"}, reg_W_addr, 5'd0);
    check_eq({tag, "/wdata"}, wdata, 32'd0);
    check_eq({tag, "/align_err"}, align_err, 1'b0);
  endtask

  // Called at a negedge with this cycle's inputs applied; returns at the next negedge
  task automatic cycle(input string tag);
    bit exp_we;
    #1;
    exp_we = m_valid && !hold && m_req.rw && (ref_addr(m_req) != 5'd0) && !ref_err(m_req);
    check_eq({tag, "/in_ready"}, in_ready, !hold);
    check_eq({tag, "/reg_we"}, reg_we, exp_we);
    check_eq({tag, "/pend_valid"}, pend_valid, m_valid && m_req.rw);
    check_eq({tag, "/align_err"}, align_err, m_err);
    if (m_valid && m_req.rw) check_eq({tag, "/pend_addr"}, pend_addr, ref_addr(m_req));
    if (exp_we) begin
      check_eq({tag, "/reg_W_addr"}, reg_W_addr, ref_addr(m_req));
      check_eq({tag, "/wdata"}, wdata, ref_data(m_req));
    end
    if (reg_we === 1'b1) obs_writes++;
    @(posedge clk);
    if (in_valid && !hold) begin
      m_req   = cur_req();
      m_valid = 1'b1;
      if (ref_err(m_req)) m_err = 1'b1;
    end else if (!hold) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Called at a negedge; reset takes effect immediately
  task automatic do_reset(input string tag);
    rst      = 1'b0;
    in_valid = 1'b0;
    hold     = 1'b0;
    #1;
    m_valid = 1'b0;
    m_err   = 1'b0;
    check_zero(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int w0;
    n_tests    = 0;
    n_fail     = 0;
    obs_writes = 0;
    m_valid    = 1'b0;
    m_err      = 1'b0;
    rst        = 1'b0;
    hold       = 1'b0;
    set_req(1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    do_reset("reset");
    cycle("idle");

    // ALU writeback to rd
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd3, 5'd5, 32'h12345678, 32'd0, 32'd0);
    cycle("alu_cap");
    in_valid = 1'b0;
    #1;
    check_eq("alu/we", reg_we, 1'b1);
    check_eq("alu/addr", reg_W_addr, 5'd5);
    check_eq("alu/wdata", wdata, 32'h12345678);
    cycle("alu_wb");
    cycle("alu_after");

    // Signed then unsigned byte loads, back to back
    set_req(1'b1, 2'd1, 2'd1, 2'd2, 1'b1, 2'd2, 5'd0, 5'd7, 32'd0, 32'h80FF7F01, 32'd0);
    cycle("sbyte_cap");
    set_req(1'b1, 2'd1, 2'd1, 2'd2, 1'b0, 2'd3, 5'd0, 5'd8, 32'd0, 32'h80FF7F01, 32'd0);
    #1;
    check_eq("sbyte/wdata", wdata, 32'hFFFFFFFF);
    cycle("sbyte_wb");
    in_valid = 1'b0;
    #1;
    check_eq("ubyte/wdata", wdata, 32'h00000080);
    cycle("ubyte_wb");

    // Link to r31, with and without wrap
    set_req(1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0, 5'd1, 5'd2, 32'd0, 32'd0, 32'h00400010);
    cycle("link_cap");
    set_req(1'b1, 2'd2, 2'd2, 2'd0, 1'b0, 2'd0, 5'd1, 5'd2, 32'd0, 32'd0, 32'hFFFFFFFC);
    #1;
    check_eq("link/addr", reg_W_addr, 5'd31);
    check_eq("link/wdata", wdata, 32'h00400018);
    cycle("link_wb");
    set_req(1'b1, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 5'd0, 5'd9, 32'hDEADBEEF, 32'd0, 32'd0);
    #1;
    check_eq("wrap/wdata", wdata, 32'h00000004);
    cycle("wrap_wb");
    in_valid = 1'b0;
    #1;
    check_eq("r0/we", reg_we, 1'b0);
    check_eq("r0/pend_valid", pend_valid, 1'b1);
    check_eq("r0/pend_addr", pend_addr, 5'd0);
    cycle("r0_wb");

    // Three requests with a two-cycle hold after the first
    w0 = obs_writes;
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd0, 5'd10, 32'hA0A0A0A0, 32'd0, 32'd0);
    cycle("b2b_a");
    hold = 1'b1;
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd0, 5'd11, 32'hB1B1B1B1, 32'd0, 32'd0);
    cycle("b2b_h1");
    cycle("b2b_h2");
    hold = 1'b0;
    cycle("b2b_b");
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd0, 5'd12, 32'hC2C2C2C2, 32'd0, 32'd0);
    cycle("b2b_c");
    in_valid = 1'b0;
    cycle("b2b_d1");
    cycle("b2b_d2");
    check_eq("b2b/count", obs_writes - w0, 3);

    // Reset while a request waits for its write cycle
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd0, 5'd13, 32'h55AA55AA, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    m_valid  = 1'b0;
    m_err    = 1'b0;
    #1;
    check_zero("rst_mid");
    @(negedge clk);
    rst = 1'b1;
    cycle("rst_rel1");
    cycle("rst_rel2");

    // Misaligned half sets a sticky error; later good requests still write
    set_req(1'b1, 2'd1, 2'd1, 2'd1, 1'b0, 2'd1, 5'd0, 5'd14, 32'd0, 32'h12345678, 32'd0);
    cycle("mis_cap");
    set_req(1'b1, 2'd0, 2'd1, 2'd0, 1'b0, 2'd0, 5'd0, 5'd15, 32'h0000BEEF, 32'd0, 32'd0);
    #1;
    check_eq("mis/we", reg_we, 1'b0);
    check_eq("mis/align_err", align_err, 1'b1);
    cycle("mis_wb");
    in_valid = 1'b0;
    #1;
    check_eq("mis/good_we", reg_we, 1'b1);
    check_eq("mis/sticky", align_err, 1'b1);
    cycle("good_wb");
    cycle("sticky_idle");

    // Randomized traffic
    do_reset("rand_rst");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pcv;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_rst");
        continue;
      end
      pcv = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : $urandom;
      set_req(1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
              2'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, pcv);
      if ($urandom_range(0, 7) == 0) wb_sel = 2'd3;
      else if ($urandom_range(0, 3) != 0) wb_sel = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) dst_sel = 2'($urandom_range(0, 2));
      // Keep most loads aligned so writes actually happen
      if ($urandom_range(0, 3) != 0) begin
        ld_size = 2'($urandom_range(0, 2));
        if (ld_size == 2'd0) byte_off = 2'd0;
        if (ld_size == 2'd1) byte_off[0] = 1'b0;
      end
      in_valid = ($urandom_range(0, 9) < 7);
      hold     = ($urandom_range(0, 3) == 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
